regbank_wb: RTL and testbench
=============================

// Module: regbank_wb
// PURPOSE
// Reader/consumer end of the pipeline register: accepts scalar writeback requests
// (dest address + 32-bit result) and commits them into a 16x32 register bank.
// A memory-load return path shares the single bank write port with priority.
// Writebacks are buffered in a small FIFO with a valid/ready handshake. Two read
// ports return the newest architectural value, including pending writes, to decode.
// PARAMETERS
// DW     32  data width of bank entries and all data ports
// AW     4   register address width; bank has 2**AW entries
// DEPTH  2   writeback FIFO depth; legal 2..4
// PORTS
// clk       in   1   single clock, all state updates on rising edge
// rst_n     in   1   synchronous reset, active-low
// wb_valid  in   1   writeback request valid
// wb_ready  out  1   FIFO can accept; transfer when wb_valid && wb_ready
// wb_addr   in   AW  destination register of writeback
// wb_data   in   DW  writeback data
// ld_valid  in   1   load return; no backpressure, always written this edge
// ld_addr   in   AW  load destination register
// ld_data   in   DW  load data
// ra_addr   in   AW  read port A address
// ra_data   out  DW  read port A data, combinational
// rb_addr   in   AW  read port B address
// rb_data   out  DW  read port B data, combinational
// fifo_cnt  out  3   number of pending writebacks, 0..DEPTH
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all bank entries <= 0, FIFO emptied, fifo_cnt <= 0.
//   While rst_n=0: wb_ready=0, ra_data=rb_data=0. Reset mid-transfer drops all pending writes.
// - wb_ready = rst_n && (fifo_cnt < DEPTH). Depends on registered state only.
//   No pass-through when full: a pop in the same cycle does not raise wb_ready.
// - Push: on edge with wb_valid && wb_ready, {wb_addr,wb_data} goes to the FIFO tail.
// - Commit, one write per edge:
//   - If ld_valid, bank[ld_addr] <= ld_data and the FIFO is not popped.
//   - Otherwise, if fifo_cnt > 0, pop the head and write bank[head.addr] <= head.data.
// - Simultaneous push and pop: fifo_cnt is unchanged and FIFO order is preserved.
// - Sustained ld_valid stalls commits. The FIFO fills and wb_ready drops after DEPTH pushes.
// - Ordering: FIFO entries are younger than any concurrent or later ld write to the same address.
// - Read value for addr X, highest priority first:
//   1. Youngest FIFO entry with addr==X.
//   2. Else ld_data, if ld_valid && ld_addr==X.
//   3. Else bank[X].
// - Latency:
//   - Write pushed at edge t is visible on read ports from cycle t+1 via bypass.
//   - It reaches the bank at edge t+1 at the earliest.
//   - With ld_valid low: DEPTH back-to-back pushes sustain one per cycle, fifo_cnt stays at 1.
// - Pointer wrap: head/tail counters wrap modulo DEPTH. fifo_cnt never exceeds DEPTH.
// - All 2**AW registers are writable; no hardwired-zero register.
// STRUCTURE
// - Shared package procfilt_pkg:
//   - DW/AW constants
//   - typedef wb_req_t {logic [AW-1:0] addr; logic [DW-1:0] data;}
// - Sub-module wb_fifo:
//   - DEPTH-entry synchronous FIFO of wb_req_t with push/pop/cnt.
//   - Exposes all entries plus valid mask and age order for the bypass search.
// - Bank array and read/bypass muxing stay in regbank_wb.
// TESTING
// - Reset: hold rst_n=0 2 cycles -> wb_ready=0, fifo_cnt=0; then ra_addr=5 -> ra_data=0 and wb_ready=1.
// - Single write: push addr=3 data=0xDEADBEEF at t -> ra_data=0xDEADBEEF at t+1 (bypass),
//   fifo_cnt=0 at t+2, value held from the bank.
// - Backpressure: ld_valid=1 every cycle, push 3 writes -> first 2 accepted, wb_ready=0 on 3rd.
//   Drop ld_valid -> FIFO drains 1/cycle, then 3rd accepted.
// - Priority: same cycle ld addr=7 data=0x11, FIFO holds addr=7 data=0x22
//   -> rb_data=0x22, bank[7] ends 0x22 after drain.
// - Youngest match: push addr=2 0xA then addr=2 0xB while ld_valid=1 -> ra_data=0xB;
//   after drain bank[2]=0xB.
// - Reset mid-operation: FIFO full (addr 1,4), rst_n=0 one cycle -> bank[1]=bank[4]=0, fifo_cnt=0.

Source files
------------

// File: rtl/procfilt_pkg.sv
// Shared widths and the writeback request bundle
// used by the register bank and its writeback FIFO.
package procfilt_pkg;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry writeback FIFO: push/pop/cnt, plus all entries
// in age order (ent[0] = head) with a valid mask for bypass.
module wb_fifo
  import procfilt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  wb_req_t        din,
  input  logic           pop,
  output logic [2:0]     cnt,
  output wb_req_t        ent [DEPTH],
  output logic [DEPTH-1:0] vld
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] DCNT = 3'(DEPTH);

  // Storage sized for the largest legal depth so
  // the 2-bit pointers index it without truncation.
  wb_req_t    mem [4];
  logic [1:0] hd;
  logic [1:0] tl;
  logic [2:0] idx [DEPTH];

  function automatic logic [1:0] nxt(
    input logic [1:0] p
  );
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[tl] <= din;
        tl      <= nxt(tl);
      end
      if (pop) hd <= nxt(hd);
      unique case (1'b1)
        push && !pop: cnt <= cnt + 3'd1;
        pop && !push: cnt <= cnt - 3'd1;
        default:      ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      idx[i] = {1'b0, hd} + 3'(i);
      if (idx[i] >= DCNT)
        idx[i] = idx[i] - DCNT;
      ent[i] = mem[idx[i][1:0]];
      vld[i] = 3'(i) < cnt;
    end
  end

endmodule

// File: rtl/regbank_wb.sv
// 16x32 register bank fed by a buffered writeback port and a
// priority load-return port; two bypassing combinational reads.
module regbank_wb
  import procfilt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  output logic [2:0]    fifo_cnt
);

  localparam int         NREG = 2 ** AW;
  localparam logic [2:0] DCNT = 3'(DEPTH);

  logic [DW-1:0]    bank [NREG];
  wb_req_t          ent  [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             push;
  logic             pop;
  wb_req_t          din;

  assign wb_ready = rst_n && (fifo_cnt < DCNT);
  assign push     = wb_valid && wb_ready;
  // Load returns own the write port; FIFO waits.
  assign pop      = rst_n && !ld_valid
                 && (fifo_cnt != 3'd0);
  assign din      = '{addr: wb_addr, data: wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .cnt   (fifo_cnt),
    .ent   (ent),
    .vld   (vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        bank[i] <= '0;
    end else if (ld_valid) begin
      bank[ld_addr] <= ld_data;
    end else if (pop) begin
      bank[ent[0].addr] <= ent[0].data;
    end
  end

  // Oldest-to-youngest scan so the youngest
  // matching FIFO entry wins over ld and bank.
  function automatic logic [DW-1:0] rd(
    input logic [AW-1:0] a
  );
    logic [DW-1:0] v;
    v = bank[a];
    if (ld_valid && ld_addr == a)
      v = ld_data;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && ent[i].addr == a)
        v = ent[i].data;
    return v;
  endfunction

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (rst_n) begin
      ra_data = rd(ra_addr);
      rb_data = rd(rb_addr);
    end
  end

endmodule

// File: tb/tb_regbank_wb.sv
// Scoreboard bench for regbank_wb: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_regbank_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ra_addr;
  logic [31:0] ra_data;
  logic [3:0]  rb_addr;
  logic [31:0] rb_data;
  logic [2:0]  fifo_cnt;

  localparam int S_RA  = 0;
  localparam int S_RB  = 1;
  localparam int S_CNT = 2;
  localparam int S_RDY = 3;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] exp;
    int          due;
  } item_t;

  item_t q  [$];
  string nq [$];
  int    cyc    = 0;
  int    tests  = 0;
  int    fails  = 0;

  regbank_wb #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ra_addr  (ra_addr),
    .ra_data  (ra_data),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every item due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      string nm;
      logic [31:0] act;
      it = q.pop_front();
      nm = nq.pop_front();
      case (it.sel)
        2'd0:    act = ra_data;
        2'd1:    act = rb_data;
        2'd2:    act = {29'd0, fifo_cnt};
        default: act = {31'd0, wb_ready};
      endcase
      tests++;
      if (it.due != cyc || act !== it.exp) begin
        fails++;
        $display("FAIL %s: got %h want %h (cyc %0d due %0d)",
                 nm, act, it.exp, cyc, it.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input int          sel,
    input logic [3:0]  a,
    input logic [31:0] e
  );
    item_t it;
    if (sel == S_RA) ra_addr = a;
    if (sel == S_RB) rb_addr = a;
    it.sel = 2'(sel);
    it.exp = e;
    it.due = cyc;
    q.push_back(it);
    nq.push_back(nm);
  endtask

  task automatic wb(
    input logic        v,
    input logic [3:0]  a,
    input logic [31:0] d
  );
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic ld(
    input logic        v,
    input logic [3:0]  a,
    input logic [31:0] d
  );
    ld_valid = v;
    ld_addr  = a;
    ld_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    wb(0, 0, 0);
    ld(0, 0, 0);
    ra_addr = 4'd5;
    rb_addr = 4'd0;

    // Reset
    tick();
    tick();
    chk("rst_rdy", S_RDY, 0, 0);
    chk("rst_cnt", S_CNT, 0, 0);
    chk("rst_ra",  S_RA,  5, 0);
    tick();
    rst_n = 1'b1;
    chk("post_rst_ra",  S_RA,  5, 0);
    chk("post_rst_rdy", S_RDY, 0, 1);

    // Single write with bypass then commit
    wb(1, 3, 32'hDEADBEEF);
    tick();
    wb(0, 0, 0);
    chk("single_byp", S_RA,  3, 32'hDEADBEEF);
    chk("single_c1",  S_CNT, 0, 1);
    tick();
    chk("single_c0",  S_CNT, 0, 0);
    chk("single_bk",  S_RA,  3, 32'hDEADBEEF);

    // Backpressure under sustained ld_valid
    ld(1, 9, 32'h99);
    wb(1, 10, 32'h100);
    chk("bp_rdy0", S_RDY, 0, 1);
    tick();
    chk("bp_cnt1", S_CNT, 0, 1);
    chk("bp_rdy1", S_RDY, 0, 1);
    wb(1, 11, 32'h200);
    tick();
    chk("bp_cnt2", S_CNT, 0, 2);
    chk("bp_full", S_RDY, 0, 0);
    wb(1, 12, 32'h300);
    tick();
    chk("bp_held", S_CNT, 0, 2);
    chk("bp_stall", S_RDY, 0, 0);
    ld(0, 0, 0);
    tick();
    chk("bp_drn1", S_CNT, 0, 1);
    chk("bp_rdy2", S_RDY, 0, 1);
    tick();
    wb(0, 0, 0);
    chk("bp_swap", S_CNT, 0, 1);
    tick();
    chk("bp_empty", S_CNT, 0, 0);
    chk("bp_r10", S_RA, 10, 32'h100);
    chk("bp_r11", S_RB, 11, 32'h200);
    tick();
    chk("bp_r12", S_RA, 12, 32'h300);
    chk("bp_r9",  S_RB, 9,  32'h99);

    // FIFO beats concurrent ld to the same register
    wb(1, 7, 32'h22);
    tick();
    wb(0, 0, 0);
    ld(1, 7, 32'h11);
    chk("pri_rb", S_RB, 7, 32'h22);
    tick();
    ld(1, 8, 32'h88);
    chk("pri_hold", S_CNT, 0, 1);
    chk("ld_byp",   S_RA,  8, 32'h88);
    chk("pri_rb2",  S_RB,  7, 32'h22);
    tick();
    ld(0, 0, 0);
    chk("pri_rb3", S_RB, 7, 32'h22);
    tick();
    chk("pri_c0", S_CNT, 0, 0);
    chk("pri_bk", S_RB,  7, 32'h22);
    chk("ld_bk",  S_RA,  8, 32'h88);

    // Youngest match wins
    ld(1, 13, 32'hD);
    wb(1, 2, 32'hA);
    tick();
    wb(1, 2, 32'hB);
    tick();
    wb(0, 0, 0);
    chk("yng_ra",  S_RA,  2, 32'hB);
    chk("yng_cnt", S_CNT, 0, 2);
    ld(0, 0, 0);
    tick();
    chk("yng_mid", S_RA, 2, 32'hB);
    tick();
    chk("yng_c0", S_CNT, 0, 0);
    chk("yng_bk", S_RA,  2, 32'hB);
    chk("yng_ld", S_RB,  13, 32'hD);

    // Back-to-back throughput with ld idle
    wb(1, 5, 32'h55);
    tick();
    wb(1, 6, 32'h66);
    chk("thr_c1a", S_CNT, 0, 1);
    tick();
    wb(0, 0, 0);
    chk("thr_c1b", S_CNT, 0, 1);
    tick();
    chk("thr_c0", S_CNT, 0, 0);
    chk("thr_r5", S_RA, 5, 32'h55);
    chk("thr_r6", S_RB, 6, 32'h66);

    // Reset with a full FIFO
    ld(1, 14, 32'hE);
    wb(1, 1, 32'h1111);
    tick();
    wb(1, 4, 32'h4444);
    tick();
    wb(0, 0, 0);
    chk("mr_cnt", S_CNT, 0, 2);
    chk("mr_r1",  S_RA,  1, 32'h1111);
    chk("mr_r4",  S_RB,  4, 32'h4444);
    tick();
    rst_n = 1'b0;
    ld(0, 0, 0);
    chk("mr_in_ra", S_RA, 1, 0);
    tick();
    rst_n = 1'b1;
    chk("mr_c0", S_CNT, 0, 0);
    chk("mr_b1", S_RA,  1, 0);
    chk("mr_b4", S_RB,  4, 0);
    tick();
    chk("mr_b14", S_RB, 14, 0);
    chk("mr_b3",  S_RA, 3,  0);
    tick();
    chk("mr_b1b", S_RA, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL unchecked: got %0d left want 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
